// File: rtl/decoder_stage_controller_pkg.sv
// Shared parameters for the union-find decoder: the stage encodings broadcast
// to every processing unit, plus a helper for sizing counters.
package decoder_stage_controller_pkg;

    localparam int STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;

    // Bits needed to hold every value 0..limit, never less than one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/decoder_stage_controller_busy_odd_reducer.sv
// Registered OR-reduction of the per-PU busy and odd flags. This is the only
// place where the full PU_COUNT fan-in is built; one cycle of latency.
module decoder_stage_controller_busy_odd_reducer #(
    parameter int PU_COUNT = 40
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PU_COUNT-1:0] i_busy,
    input  logic [PU_COUNT-1:0] i_odd,
    output logic                o_busy_any,
    output logic                o_odd_any
);

    logic r_busy_any;
    logic r_odd_any;

    // Register the reduced flags so the wide OR tree has a full cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_any <= 1'b0;
            r_odd_any  <= 1'b0;
        end else begin
            r_busy_any <= |i_busy;
            r_odd_any  <= |i_odd;
        end
    end

    assign o_busy_any = r_busy_any;
    assign o_odd_any  = r_odd_any;

endmodule

// File: rtl/decoder_stage_controller.sv
// Global stage sequencer for the union-find decoder: IDLE -> LOAD -> (GROW ->
// MERGE)* -> PEELING, with iteration limit and a merge watchdog.
module decoder_stage_controller
    import decoder_stage_controller_pkg::*;
#(
    parameter int PU_COUNT         = 40,
    parameter int ITER_WIDTH       = 8,
    parameter int MAX_ITERATIONS   = 32,
    parameter int GROW_CYCLES      = 2,
    parameter int MERGE_SETTLE     = 2,
    parameter int MAX_MERGE_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   ready,
    input  logic [PU_COUNT-1:0]    busy,
    input  logic [PU_COUNT-1:0]    odd,
    output logic [STAGE_WIDTH-1:0] global_stage,
    output logic [ITER_WIDTH-1:0]  iteration,
    output logic                   result_valid,
    input  logic                   result_ack,
    output logic                   timeout
);

    // PU stage register + PU busy register + reducer register.
    localparam int MERGE_BLANK = 3;

    localparam int GC_W = cnt_width(GROW_CYCLES);
    localparam int MC_W = cnt_width((MAX_MERGE_CYCLES > MERGE_BLANK) ? MAX_MERGE_CYCLES : MERGE_BLANK);
    localparam int QC_W = cnt_width(MERGE_SETTLE);

    localparam logic [GC_W-1:0]       GROW_LAST     = GC_W'(GROW_CYCLES - 1);
    localparam logic [MC_W-1:0]       MERGE_LIMIT   = MC_W'(MAX_MERGE_CYCLES);
    localparam logic [MC_W-1:0]       BLANK_CYCLES  = MC_W'(MERGE_BLANK);
    localparam logic [QC_W-1:0]       SETTLE_TARGET = QC_W'(MERGE_SETTLE);
    localparam logic [ITER_WIDTH-1:0] ITER_LIMIT    = ITER_WIDTH'(MAX_ITERATIONS);
    localparam logic [ITER_WIDTH-1:0] ITER_SAT      = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_GROW  = 3'd2,
        ST_MERGE = 3'd3,
        ST_PEEL  = 3'd4
    } state_t;

    state_t                 r_state;
    logic [STAGE_WIDTH-1:0] r_stage;
    logic                   r_ready;
    logic                   r_result_valid;
    logic                   r_timeout;
    logic [ITER_WIDTH-1:0]  r_iteration;
    logic [GC_W-1:0]        r_grow_cnt;
    logic [MC_W-1:0]        r_merge_cnt;   // MERGE cycles completed before the current one
    logic [QC_W-1:0]        r_quiet_cnt;

    logic                   w_busy_any;
    logic                   w_odd_any;
    logic                   w_blanking;
    logic                   w_settled;
    logic                   w_watchdog;
    logic [MC_W-1:0]        w_merge_cnt_inc;
    logic [QC_W-1:0]        w_quiet_inc;
    logic [ITER_WIDTH-1:0]  w_iter_inc;

    decoder_stage_controller_busy_odd_reducer #(
        .PU_COUNT (PU_COUNT)
    ) u_reducer (
        .clk        (clk),
        .reset      (reset),
        .i_busy     (busy),
        .i_odd      (odd),
        .o_busy_any (w_busy_any),
        .o_odd_any  (w_odd_any)
    );

    assign w_merge_cnt_inc = (r_merge_cnt == MERGE_LIMIT) ? r_merge_cnt : (r_merge_cnt + MC_W'(1));
    assign w_blanking      = (r_merge_cnt < BLANK_CYCLES);
    assign w_quiet_inc     = r_quiet_cnt + QC_W'(1);
    assign w_settled       = !w_blanking && !w_busy_any && (w_quiet_inc == SETTLE_TARGET);
    // Fires on the last permitted MERGE cycle so MERGE lasts exactly MAX_MERGE_CYCLES.
    assign w_watchdog      = (w_merge_cnt_inc == MERGE_LIMIT);
    assign w_iter_inc      = (r_iteration == ITER_SAT) ? r_iteration : (r_iteration + ITER_WIDTH'(1));

    // Sequencer FSM; every output is registered and updated with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_stage        <= STAGE_IDLE;
            r_ready        <= 1'b1;
            r_result_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_iteration    <= '0;
            r_grow_cnt     <= '0;
            r_merge_cnt    <= '0;
            r_quiet_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_LOAD;
                        r_stage     <= STAGE_MEASUREMENT_LOADING;
                        r_ready     <= 1'b0;
                        r_iteration <= '0;
                        r_timeout   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_state     <= ST_GROW;
                    r_stage     <= STAGE_GROW;
                    r_grow_cnt  <= '0;
                    r_merge_cnt <= '0;
                    r_quiet_cnt <= '0;
                end
                ST_GROW: begin
                    if (r_grow_cnt == GROW_LAST) begin
                        r_state <= ST_MERGE;
                        r_stage <= STAGE_MERGE;
                    end else begin
                        r_grow_cnt <= r_grow_cnt + GC_W'(1);
                    end
                end
                ST_MERGE: begin
                    r_merge_cnt <= w_merge_cnt_inc;
                    // Reducer output is stale until the PU pipeline has seen STAGE_MERGE.
                    if (!w_blanking) begin
                        r_quiet_cnt <= w_busy_any ? '0 : w_quiet_inc;
                    end
                    if (w_settled) begin
                        r_iteration <= w_iter_inc;
                        if (!w_odd_any) begin
                            r_state        <= ST_PEEL;
                            r_stage        <= STAGE_PEELING;
                            r_result_valid <= 1'b1;
                            r_timeout      <= 1'b0;
                        end else if (w_iter_inc == ITER_LIMIT) begin
                            r_state        <= ST_PEEL;
                            r_stage        <= STAGE_PEELING;
                            r_result_valid <= 1'b1;
                            r_timeout      <= 1'b1;
                        end else begin
                            r_state     <= ST_GROW;
                            r_stage     <= STAGE_GROW;
                            r_grow_cnt  <= '0;
                            r_merge_cnt <= '0;
                            r_quiet_cnt <= '0;
                        end
                    end else if (w_watchdog) begin
                        r_state        <= ST_PEEL;
                        r_stage        <= STAGE_PEELING;
                        r_result_valid <= 1'b1;
                        r_timeout      <= 1'b1;
                    end
                end
                ST_PEEL: begin
                    if (result_ack) begin
                        r_state        <= ST_IDLE;
                        r_stage        <= STAGE_IDLE;
                        r_result_valid <= 1'b0;
                        r_ready        <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_stage        <= STAGE_IDLE;
                    r_ready        <= 1'b1;
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

    assign global_stage = r_stage;
    assign ready        = r_ready;
    assign result_valid = r_result_valid;
    assign timeout      = r_timeout;
    assign iteration    = r_iteration;

endmodule
